// File: rtl/parity_frame_fsm.sv
// ---------------------------------------------------------------------------
// parity_frame_fsm
//
// Streaming parity generator / checker. Data words arrive on a valid/ready
// input and are grouped into frames of FRAME_LEN words. A single parity bit
// is produced per frame on a valid/ready output:
//     par_bit = XOR of every data bit in the frame ^ ODD
//
// Generate mode (check_en=0 on the first word of a frame):
//     FRAME_LEN data words, then the result.
// Check mode (check_en=1 on the first word of a frame):
//     FRAME_LEN data words, then one extra parity word. Bit 0 of that word is
//     the received parity. par_err flags a disagreement with par_bit.
//
// Ports:
//     clk        clock, all state updates on the rising edge
//     rst        synchronous active-low reset
//     in_valid   source has a word
//     in_ready   block can take a word (low while a result is pending)
//     in_data    data word, or the received parity in bit 0 (check mode)
//     check_en   frame mode, sampled on the first accepted word of a frame
//     par_valid  frame result available
//     par_ready  sink takes the result
//     par_bit    frame parity, held between frames
//     par_err    check-mode parity mismatch, held between frames
//     run_odd    running XOR of the data words accepted in this frame
//     frame_cnt  completed frames, wraps
//     err_cnt    frames completed with par_err=1, saturates
// ---------------------------------------------------------------------------
module parity_frame_fsm #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             check_en,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             par_bit,
    output logic             par_err,
    output logic             run_odd,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // state  | meaning
    // -------+-------------------------------------------------------------
    // S_IDLE | waiting for the first word of a frame; latches the mode
    // S_ACC  | folding data words into acc; in check mode, once all data
    //        | words are in, the next word is the received parity
    // S_OUT  | result presented on par_*; input stalled until par_ready

    // Word count must reach FRAME_LEN and still fit, hence FRAME_LEN+2.
    localparam int             CW    = $clog2(FRAME_LEN + 2);
    localparam logic [CW-1:0]  LAST  = CW'(FRAME_LEN);
    localparam logic           ODD_B = (ODD != 0);
    localparam logic           ONE_WORD_FRAME = (FRAME_LEN == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic             acc;
    logic             acc_d;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_d;
    logic             mode;
    logic             mode_d;
    logic             par_bit_q;
    logic             par_bit_d;
    logic             par_err_q;
    logic             par_err_d;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    logic             accept;
    logic             word_par;
    logic             err_sat;

    assign accept   = in_valid & in_ready;
    assign word_par = ^in_data;
    assign err_sat  = &err_cnt_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            acc         <= 1'b0;
            cnt         <= '0;
            mode        <= 1'b0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            cnt         <= cnt_d;
            mode        <= mode_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        mode_d      = mode;
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    acc_d  = word_par;
                    cnt_d  = CW'(1);
                    mode_d = check_en;
                    // A one-word generate frame is complete on its first word.
                    if (ONE_WORD_FRAME && !check_en) begin
                        state_d   = S_OUT;
                        par_bit_d = word_par ^ ODD_B;
                        par_err_d = 1'b0;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end

            S_ACC: begin
                if (accept) begin
                    if (cnt < LAST) begin
                        acc_d = acc ^ word_par;
                        cnt_d = cnt + 1'b1;
                        if (!mode && (cnt_d == LAST)) begin
                            state_d   = S_OUT;
                            par_bit_d = acc_d ^ ODD_B;
                            par_err_d = 1'b0;
                        end
                    end else begin
                        // Only reachable in check mode: this is the parity
                        // word, compared but never folded into acc.
                        state_d   = S_OUT;
                        par_bit_d = acc ^ ODD_B;
                        par_err_d = in_data[0] ^ (acc ^ ODD_B);
                    end
                end
            end

            S_OUT: begin
                if (par_ready) begin
                    state_d     = S_IDLE;
                    acc_d       = 1'b0;
                    cnt_d       = '0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (par_err_q && !err_sat) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                acc_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state != S_OUT);
        par_valid = (state == S_OUT);
        par_bit   = par_bit_q;
        par_err   = par_err_q;
        run_odd   = acc;
        frame_cnt = frame_cnt_q;
        err_cnt   = err_cnt_q;
    end

endmodule

// File: doc/parity_frame_fsm.md
Name: parity_frame_fsm

Overview:
- Streaming parity generator/checker FSM; successor to the 3-bit parity Moore FSM.
- Generalised to WIDTH-bit words grouped into frames of FRAME_LEN words, with selectable even/odd sense.
- Adds valid/ready handshakes on input and output, a per-frame check mode and a saturating error counter.
- Sits between a word source and a framing/link layer; emits one parity bit per frame.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- FRAME_LEN, 4, data words per frame (>=1).
- ODD, 0, 0 = even parity (par_bit makes total ones even), 1 = odd parity.
- CNT_W, 16, width of frame_cnt and err_cnt.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- in_valid  in  1  source has a word.
- in_ready  out  1  block accepts a word; transfer when in_valid&in_ready.
- in_data  in  WIDTH  data word; in check mode the extra trailing word carries the received parity in bit 0.
- check_en  in  1  0 = generate, 1 = check; sampled only on the first accepted word of a frame.
- par_valid  out  1  frame result available.
- par_ready  in  1  sink takes result; handshake when par_valid&par_ready.
- par_bit  out  1  computed parity for the frame = XOR of all frame data bits ^ ODD.
- par_err  out  1  check mode only: received parity != par_bit; 0 in generate mode.
- run_odd  out  1  running XOR of data bits accepted so far in the current frame.
- frame_cnt  out  CNT_W  completed frames (output handshakes), wraps modulo 2^CNT_W.
- err_cnt  out  CNT_W  frames completed with par_err=1; saturates at all-ones.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; acc=0; word count=0; mode=0.
  - par_valid=0, par_bit=0, par_err=0, run_odd=0, frame_cnt=0, err_cnt=0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-frame or mid-output discards the frame without an output handshake.
- States:
  - IDLE: in_ready=1. On accept:
    - acc = ^in_data; cnt = 1; latch mode = check_en.
    - Next state is OUT if FRAME_LEN==1 and mode==0, else ACC.
  - ACC: in_ready=1. On accept of a data word (cnt < FRAME_LEN):
    - acc ^= ^in_data; cnt++.
    - Move to OUT when cnt reaches FRAME_LEN in generate mode.
  - ACC in check mode, word FRAME_LEN+1 (cnt == FRAME_LEN):
    - This is the parity word and is not folded into acc.
    - Register rx = in_data[0]; go to OUT.
  - OUT: in_ready=0; par_valid=1.
    - par_bit = acc ^ ODD.
    - par_err = mode & (rx != par_bit).
    - Outputs are held stable until par_ready.
    - On handshake: frame_cnt++; err_cnt++ if par_err and not saturated; acc=0; cnt=0; state=IDLE.
- Latency:
  - par_valid rises the cycle after the posedge that accepts the last word of the frame (data word in generate mode, parity word in check mode).
  - Minimum frame period is FRAME_LEN+1 cycles in generate mode and FRAME_LEN+2 in check mode.
  - No overlap: no input is accepted while par_valid=1.
- run_odd:
  - Equals acc, registered.
  - Updates the cycle after each accepted data word.
  - Returns to 0 after the output handshake.
- Idle input: in_valid=0 causes no state change; gaps between words are allowed anywhere.
- check_en changes mid-frame are ignored until the next IDLE accept.
- Held values: par_bit and par_err keep their last frame's values while par_valid=0. They are only meaningful when par_valid=1.

Test Plan:
- Generate mode, even parity (ODD=0, WIDTH=8, FRAME_LEN=4): words 0x01,0x03,0x00,0xFF with back-to-back valid -> par_valid rises one cycle after the 4th accept; par_bit=1, par_err=0, frame_cnt=1.
- Odd parity (ODD=1): same frame -> par_bit=0. All-zero frame -> par_bit=1.
- Check mode, good and bad: 4 data words 0x01,0x00,0x00,0x00 then parity word 0x01 -> par_err=0. Repeat with parity word 0x00 -> par_err=1, err_cnt=1.
- Backpressure: par_ready=0 for 5 cycles -> par_valid, par_bit and par_err stay stable, in_ready=0; frame_cnt increments only on the handshake.
- Input gaps and mode change: in_valid toggling 1/0 across the frame, check_en toggled after the first word -> result identical to the gap-free run with the mode latched at frame start.
- Reset and saturation:
  - rst=0 after the 2nd word -> next cycle in_ready=1, run_odd=0, counters=0; the next frame is computed from scratch.
  - With CNT_W=2, 4 failing frames -> err_cnt stays at 3.
